// File: rtl/sprite_fetch_ctrl.sv
// Purpose: copies one sprite's pixel bytes from SDRAM into sprite RAM by driving the
//          Avalon read-master DMA and draining its byte buffer into a RAM write port.
// Latency: start -> ctl_go 2 cycles; a zero-size or oversize request gives done 2 cycles after start.
// Backpressure: bytes are popped only when pix_ready=1; unpopped bytes wait in the master buffer.
// Ports:
//   clk_clk, reset_reset_n           clock, synchronous active-low reset
//   start, sprite_*                  request and sprite descriptor (address/width/height/id)
//   busy, done, err                  status; done/err are 1-cycle pulses
//   ctl_*                            Avalon read-master control interface
//   usr_*                            Avalon read-master show-ahead user buffer
//   pix_*                            sprite RAM write port, with pixel x/y coordinates
module sprite_fetch_ctrl #(
  parameter int MAX_BYTES = 4096,
  parameter int SLOT_W    = 4,
  parameter int ADDR_W    = 12
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              start,
  input  logic [31:0]       sprite_address,
  input  logic [15:0]       sprite_width,
  input  logic [15:0]       sprite_height,
  input  logic [15:0]       sprite_id,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ctl_fixed_location,
  output logic [31:0]       ctl_read_base,
  output logic [31:0]       ctl_read_length,
  output logic              ctl_go,
  input  logic              ctl_done,
  input  logic              usr_data_available,
  input  logic [7:0]        usr_data,
  output logic              usr_read_buffer,
  input  logic              pix_ready,
  output logic              pix_we,
  output logic [SLOT_W-1:0] pix_slot,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [7:0]        pix_data,
  output logic [15:0]       pix_x,
  output logic [15:0]       pix_y
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    GO     = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t state, state_nx;

  logic [31:0]       addr_r;
  logic [15:0]       width_r;
  logic [15:0]       height_r;
  logic [SLOT_W-1:0] slot_r;
  logic [31:0]       len_r;
  logic              err_r;
  logic [ADDR_W-1:0] count_r;
  logic [15:0]       x_r;
  logic [15:0]       y_r;

  logic [31:0] prod;
  logic        too_big;
  logic        empty;
  logic        pop;
  logic        last;

  // Only the low SLOT_W bits of the id select a slot.
  logic unused_id;
  assign unused_id = ^sprite_id[15:SLOT_W];

  assign prod    = 32'(width_r) * 32'(height_r);
  assign too_big = (prod > 32'(MAX_BYTES));
  assign empty   = (prod == 32'd0);
  // count never exceeds MAX_BYTES-1, so zero-extending it to 32 bits is exact.
  assign last    = ({{(32-ADDR_W){1'b0}}, count_r} == (len_r - 32'd1));

  assign ctl_fixed_location = 1'b0;

  // State register
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CHECK;
      CHECK:   state_nx = (empty || too_big) ? FIN : GO;
      GO:      state_nx = STREAM;
      STREAM:  if (pop && last) state_nx = DRAIN;
      // ctl_done is only looked at here, well after go, so its idle-high level is never seen.
      DRAIN:   if (ctl_done) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy            = (state != IDLE);
    done            = (state == FIN);
    err             = (state == FIN) && err_r;
    ctl_go          = (state == GO);
    pop             = (state == STREAM) && usr_data_available && pix_ready;
    usr_read_buffer = pop;
    pix_we          = pop;
    pix_slot        = pop ? slot_r  : '0;
    pix_addr        = pop ? count_r : '0;
    pix_data        = pop ? usr_data : 8'd0;
    pix_x           = pop ? x_r : 16'd0;
    pix_y           = pop ? y_r : 16'd0;
  end

  // Datapath: request latch, DMA programming, pixel counters
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      addr_r          <= 32'd0;
      width_r         <= 16'd0;
      height_r        <= 16'd0;
      slot_r          <= '0;
      len_r           <= 32'd0;
      err_r           <= 1'b0;
      count_r         <= '0;
      x_r             <= 16'd0;
      y_r             <= 16'd0;
      ctl_read_base   <= 32'd0;
      ctl_read_length <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_r   <= sprite_address;
            width_r  <= sprite_width;
            height_r <= sprite_height;
            slot_r   <= sprite_id[SLOT_W-1:0];
            err_r    <= 1'b0;
            count_r  <= '0;
            x_r      <= 16'd0;
            y_r      <= 16'd0;
          end
        end
        CHECK: begin
          if (too_big) begin
            err_r <= 1'b1;
          end else if (!empty) begin
            ctl_read_base   <= addr_r;
            ctl_read_length <= prod;
            len_r           <= prod;
          end
        end
        STREAM: begin
          if (pop) begin
            count_r <= count_r + 1'b1;
            if (x_r == width_r - 16'd1) begin
              x_r <= 16'd0;
              y_r <= y_r + 16'd1;
            end else begin
              x_r <= x_r + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
module tb_sprite_fetch_ctrl;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] sprite_address = 32'd0;
  logic [15:0] sprite_width = 16'd0;
  logic [15:0] sprite_height = 16'd0;
  logic [15:0] sprite_id = 16'd0;
  logic        busy, done, err;
  logic        ctl_fixed_location;
  logic [31:0] ctl_read_base, ctl_read_length;
  logic        ctl_go;
  logic        ctl_done = 1'b1;
  logic        usr_data_available;
  logic [7:0]  usr_data;
  logic        usr_read_buffer;
  logic        pix_ready = 1'b1;
  logic        pix_we;
  logic [3:0]  pix_slot;
  logic [11:0] pix_addr;
  logic [7:0]  pix_data;
  logic [15:0] pix_x, pix_y;

  sprite_fetch_ctrl dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .start(start),
    .sprite_address(sprite_address), .sprite_width(sprite_width),
    .sprite_height(sprite_height), .sprite_id(sprite_id),
    .busy(busy), .done(done), .err(err),
    .ctl_fixed_location(ctl_fixed_location), .ctl_read_base(ctl_read_base),
    .ctl_read_length(ctl_read_length), .ctl_go(ctl_go), .ctl_done(ctl_done),
    .usr_data_available(usr_data_available), .usr_data(usr_data),
    .usr_read_buffer(usr_read_buffer), .pix_ready(pix_ready), .pix_we(pix_we),
    .pix_slot(pix_slot), .pix_addr(pix_addr), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y)
  );

  always #5 clk_clk = ~clk_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic rdy_toggle = 1'b0;

  // Read-master stand-in: after go it offers the requested bytes plus two junk bytes,
  // and raises ctl_done once the requested bytes have all been popped.
  logic [31:0] m_base = 32'd0, m_len = 32'd0, m_ptr = 32'd0;
  logic        m_act = 1'b0;

  always @(posedge clk_clk) begin
    cyc <= cyc + 1;
    if (!reset_reset_n) begin
      m_act     <= 1'b0;
      m_ptr     <= 32'd0;
      ctl_done  <= 1'b1;
      pix_ready <= 1'b1;
    end else begin
      pix_ready <= rdy_toggle ? ~pix_ready : 1'b1;
      if (ctl_go) begin
        m_base   <= ctl_read_base;
        m_len    <= ctl_read_length;
        m_ptr    <= 32'd0;
        m_act    <= 1'b1;
        ctl_done <= 1'b0;
      end else if (m_act) begin
        if (usr_read_buffer) m_ptr <= m_ptr + 32'd1;
        if (m_ptr >= m_len) ctl_done <= 1'b1;
      end
    end
  end

  assign usr_data_available = m_act && (m_ptr < m_len + 32'd2);
  assign usr_data           = m_base[15:8] ^ m_ptr[7:0];

  // Monitor: records every pixel write and counts go/done pulses and protocol violations.
  logic [55:0] rec [0:255];
  int pop_n = 0, go_n = 0, done_n = 0, viol_n = 0;
  int go_cyc = 0, done_cyc = 0;
  logic [31:0] go_base = 32'd0, go_len = 32'd0;
  logic done_err = 1'b0;

  always @(negedge clk_clk) begin
    if (pix_we) begin
      if (pop_n < 256) rec[pop_n] = {pix_addr, pix_x, pix_y, pix_data, pix_slot};
      pop_n = pop_n + 1;
    end
    if (ctl_go) begin
      go_n = go_n + 1; go_cyc = cyc; go_base = ctl_read_base; go_len = ctl_read_length;
    end
    if (done) begin
      done_n = done_n + 1; done_cyc = cyc; done_err = err;
    end
    if (err && !done) viol_n = viol_n + 1;
    if (usr_read_buffer && !(pix_ready && usr_data_available)) viol_n = viol_n + 1;
    if (pix_we !== usr_read_buffer) viol_n = viol_n + 1;
  end

  int p0, g0, d0, v0, t0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] a, input logic [15:0] w, input logic [15:0] h,
                          input logic [15:0] id);
    tick();
    sprite_address = a; sprite_width = w; sprite_height = h; sprite_id = id;
    start = 1'b1;
    p0 = pop_n; g0 = go_n; d0 = done_n; v0 = viol_n; t0 = cyc;
    tick();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 3000; k++) begin
      if (done_n > d0) break;
      tick();
    end
    if (k == 3000) chk("done_timeout", 64'd0, 64'd1);
    repeat (4) tick();
  endtask

  task automatic verify(input logic [31:0] a, input int w, input int h, input logic [15:0] id);
    logic [11:0] ea;
    logic [15:0] ex, ey;
    logic [7:0]  ed, iv;
    int n;
    n = w * h;
    chk("go_count", 64'(go_n - g0), 64'd1);
    chk("go_latency", 64'(go_cyc - t0), 64'd2);
    chk("read_base", 64'(go_base), 64'(a));
    chk("read_length", 64'(go_len), 64'(n));
    chk("pix_count", 64'(pop_n - p0), 64'(n));
    chk("done_count", 64'(done_n - d0), 64'd1);
    chk("err_at_done", 64'(done_err), 64'd0);
    chk("violations", 64'(viol_n - v0), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
    for (int i = 0; i < n && (p0 + i) < 256; i++) begin
      ea = 12'(i); ex = 16'(i % w); ey = 16'(i / w); iv = 8'(i);
      ed = a[15:8] ^ iv;
      chk($sformatf("pixel[%0d]", i), 64'(rec[p0 + i]), 64'({ea, ex, ey, ed, id[3:0]}));
    end
  endtask

  initial begin
    int k;
    // Reset state
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_go", 64'(ctl_go), 64'd0);
    chk("rst_pix_we", 64'(pix_we), 64'd0);
    chk("rst_base", 64'(ctl_read_base), 64'd0);
    chk("rst_len", 64'(ctl_read_length), 64'd0);
    chk("fixed_location", 64'(ctl_fixed_location), 64'd0);
    reset_reset_n = 1'b1;
    repeat (3) tick();
    chk("idle_ignores_ctl_done", 64'(busy), 64'd0);

    // Basic 4x2 sprite into slot 3
    do_start(32'h0000_1000, 16'd4, 16'd2, 16'd3);
    wait_done();
    verify(32'h0000_1000, 4, 2, 16'd3);

    // Zero width: done 2 cycles after start, no go, no pixels
    do_start(32'h0000_2000, 16'd0, 16'd5, 16'd1);
    wait_done();
    chk("zero_done_latency", 64'(done_cyc - t0), 64'd2);
    chk("zero_go", 64'(go_n - g0), 64'd0);
    chk("zero_err", 64'(done_err), 64'd0);
    chk("zero_pix", 64'(pop_n - p0), 64'd0);

    // Oversize 128x64: rejected with err alongside done
    do_start(32'h0000_3000, 16'd128, 16'd64, 16'd2);
    wait_done();
    chk("big_done_count", 64'(done_n - d0), 64'd1);
    chk("big_err", 64'(done_err), 64'd1);
    chk("big_go", 64'(go_n - g0), 64'd0);
    chk("big_done_latency", 64'(done_cyc - t0), 64'd2);

    // pix_ready toggling during a 16-byte fetch
    rdy_toggle = 1'b1;
    do_start(32'h0000_2200, 16'd16, 16'd1, 16'd5);
    wait_done();
    verify(32'h0000_2200, 16, 1, 16'd5);

    // Second start mid-STREAM is ignored
    do_start(32'h0000_3300, 16'd4, 16'd4, 16'd7);
    for (k = 0; k < 200 && (pop_n - p0) < 5; k++) tick();
    sprite_address = 32'h0000_9900; sprite_width = 16'd2; sprite_height = 16'd2;
    sprite_id = 16'd9; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    verify(32'h0000_3300, 4, 4, 16'd7);
    rdy_toggle = 1'b0;

    // Reset after 3 of 8 bytes, then a fresh transfer
    do_start(32'h0000_4400, 16'd8, 16'd1, 16'd4);
    for (k = 0; k < 200 && (pop_n - p0) < 3; k++) tick();
    reset_reset_n = 1'b0;
    tick();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_pix_we", 64'(pix_we), 64'd0);
    chk("midrst_pop", 64'(usr_read_buffer), 64'd0);
    chk("midrst_go", 64'(ctl_go), 64'd0);
    chk("midrst_base", 64'(ctl_read_base), 64'd0);
    chk("midrst_len", 64'(ctl_read_length), 64'd0);
    reset_reset_n = 1'b1;
    repeat (20) tick();
    chk("midrst_no_done", 64'(done_n - d0), 64'd0);
    do_start(32'h0000_5500, 16'd2, 16'd3, 16'd9);
    wait_done();
    verify(32'h0000_5500, 2, 3, 16'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
